// File: rtl/load_store_unit_if.sv
// Pipeline-to-LSU request/response signals plus the LSU's word-wide data
// memory port, bundled so the unit and its environment share one connection.
interface load_store_unit_if;
  // pipeline request
  logic        req_i;
  logic        we_i;
  logic [1:0]  size_i;
  logic        unsigned_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  // pipeline response
  logic        stall_o;
  logic        done_o;
  logic        misalign_o;
  logic [31:0] rdata_o;
  // data memory port
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic        mem_read_o;
  logic        mem_write_o;
  logic [31:0] mem_data_i;

  // the load/store unit itself
  modport slave (
    input  req_i, we_i, size_i, unsigned_i, addr_i, wdata_i, mem_data_i,
    output stall_o, done_o, misalign_o, rdata_o,
           mem_addr_o, mem_data_o, mem_read_o, mem_write_o
  );

  // pipeline plus memory model driving the unit
  modport master (
    output req_i, we_i, size_i, unsigned_i, addr_i, wdata_i, mem_data_i,
    input  stall_o, done_o, misalign_o, rdata_o,
           mem_addr_o, mem_data_o, mem_read_o, mem_write_o
  );
endinterface

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: stalls the pipeline for each access, extracts and
// extends sub-word loads, performs sub-word stores as read-modify-write and
// rejects misaligned or reserved-size requests without touching memory.
module load_store_unit #(
  parameter int LAT = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  load_store_unit_if.slave bus
);

  localparam int            CW       = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LAT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, RESP = 2'd3} state_t;

  state_t        state_q, state_d;
  logic          we_q, we_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic [31:0]   addr_q, addr_d;
  logic [15:0]   wdata_q, wdata_d;   // only the low half is ever merged
  logic [31:0]   word_q, word_d;     // word to be written in WRITE
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          mis_q, mis_d;
  logic [31:0]   rdata_q, rdata_d;

  logic          req_misalign;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;
  logic [31:0]   load_val;
  logic [31:0]   merged;

  assign req_misalign = (bus.size_i == 2'b11)
                      | ((bus.size_i == 2'b01) & bus.addr_i[0])
                      | ((bus.size_i == 2'b10) & (|bus.addr_i[1:0]));

  // Lane extraction for loads and lane merge for sub-word stores, both from
  // the word currently returned by memory.
  always_comb begin
    byte_v = bus.mem_data_i[{addr_q[1:0], 3'b000} +: 8];
    half_v = bus.mem_data_i[{addr_q[1], 4'b0000} +: 16];
    case (size_q)
      2'b00:   load_val = uns_q ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
      2'b01:   load_val = uns_q ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
      default: load_val = bus.mem_data_i;
    endcase
    merged = bus.mem_data_i;
    if (size_q == 2'b00) begin
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else if (size_q == 2'b01) begin
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q;
    end
  end

  // Next-state logic: acceptance, read wait counting, merge, response.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    rdata_d = '0;
    mis_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_i) begin
          we_d    = bus.we_i;
          size_d  = bus.size_i;
          uns_d   = bus.unsigned_i;
          addr_d  = bus.addr_i;
          wdata_d = bus.wdata_i[15:0];
          word_d  = bus.wdata_i;
          cnt_d   = '0;
          if (req_misalign) begin
            state_d = RESP;
            mis_d   = 1'b1;
          end else if (bus.we_i && (bus.size_i == 2'b10)) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        if (cnt_q == CNT_LAST) begin
          if (we_q) begin
            word_d  = merged;
            state_d = WRITE;
          end else begin
            rdata_d = load_val;
            state_d = RESP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    done_d = (state_d == RESP);
  end

  // State and latched-field registers; reset abandons any access in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      mis_q   <= mis_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.stall_o     = ((state_q == IDLE) & bus.req_i) | (state_q == READ) | (state_q == WRITE);
  assign bus.done_o      = done_q;
  assign bus.misalign_o  = mis_q;
  assign bus.rdata_o     = rdata_q;
  assign bus.mem_read_o  = (state_q == READ);
  assign bus.mem_write_o = (state_q == WRITE);
  assign bus.mem_addr_o  = ((state_q == READ) || (state_q == WRITE)) ? {addr_q[31:2], 2'b00} : 32'h0;
  assign bus.mem_data_o  = (state_q == WRITE) ? word_q : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench: two units (LAT=1 and LAT=3) each with a small word memory.
// Stimulus pushes the hand-computed response; a per-unit monitor pops and
// compares whenever done_o is seen.
module tb_load_store_unit;

  typedef struct {
    int          dut;
    int          done_cyc;
    logic        mis;
    logic [31:0] rdata;
    int          nreads;
    int          nwrites;
    int          wcyc;
    logic [31:0] waddr;
    logic [31:0] wdata;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0;
  int nmis = 0;
  exp_t sb[$];

  logic        rst   [2];
  logic        req   [2];
  logic        we    [2];
  logic [1:0]  size  [2];
  logic        uns   [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] mem   [2][64];

  logic        stall_a [2];
  logic        done_a  [2];
  logic        mis_a   [2];
  logic [31:0] rdata_a [2];
  logic [31:0] maddr_a [2];
  logic [31:0] mdata_a [2];
  logic        mrd_a   [2];
  logic        mwr_a   [2];

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] req_v);
    nvec++;
    if (act !== req_v) begin
      nmis++;
      $display("FAIL %s dut%0d cyc %0d: got %h expected %h", nm, d, cyc, act, req_v);
    end
  endtask

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g
      localparam int L = (gi == 0) ? 1 : 3;
      load_store_unit_if ifc ();

      load_store_unit #(.LAT(L)) dut (
        .clk_i (clk),
        .rst_i (rst[gi]),
        .bus   (ifc)
      );

      assign ifc.req_i      = req[gi];
      assign ifc.we_i       = we[gi];
      assign ifc.size_i     = size[gi];
      assign ifc.unsigned_i = uns[gi];
      assign ifc.addr_i     = addr[gi];
      assign ifc.wdata_i    = wdata[gi];
      assign ifc.mem_data_i = ifc.mem_read_o ? mem[gi][ifc.mem_addr_o[7:2]] : 32'h0;

      assign stall_a[gi] = ifc.stall_o;
      assign done_a[gi]  = ifc.done_o;
      assign mis_a[gi]   = ifc.misalign_o;
      assign rdata_a[gi] = ifc.rdata_o;
      assign maddr_a[gi] = ifc.mem_addr_o;
      assign mdata_a[gi] = ifc.mem_data_o;
      assign mrd_a[gi]   = ifc.mem_read_o;
      assign mwr_a[gi]   = ifc.mem_write_o;

      // memory write port
      always @(posedge clk) begin
        if (ifc.mem_write_o) mem[gi][ifc.mem_addr_o[7:2]] = ifc.mem_data_o;
      end

      int          nr = 0;
      int          nw = 0;
      int          wc = 0;
      logic [31:0] wa = 32'h0;
      logic [31:0] wd = 32'h0;
      exp_t        e;

      // monitor: bus-activity bookkeeping and response checking
      always @(negedge clk) begin
        if (rst[gi]) begin
          nr = 0;
          nw = 0;
        end else begin
          if (ifc.mem_read_o) nr++;
          if (ifc.mem_write_o) begin
            nw++;
            wc = cyc;
            wa = ifc.mem_addr_o;
            wd = ifc.mem_data_o;
          end
          if ((ifc.mem_read_o && ifc.mem_write_o) ||
              (ifc.mem_read_o && ifc.mem_data_o != 32'h0) ||
              (!ifc.mem_read_o && !ifc.mem_write_o && (ifc.mem_addr_o != 32'h0 || ifc.mem_data_o != 32'h0)) ||
              (!ifc.done_o && (ifc.rdata_o != 32'h0 || ifc.misalign_o))) begin
            nmis++;
            $display("FAIL bus_idle_rules dut%0d cyc %0d: rd=%b wr=%b addr=%h data=%h rdata=%h mis=%b",
                     gi, cyc, ifc.mem_read_o, ifc.mem_write_o, ifc.mem_addr_o, ifc.mem_data_o,
                     ifc.rdata_o, ifc.misalign_o);
          end
          if (ifc.done_o) begin
            if (sb.size() == 0 || sb[0].dut != gi) begin
              nvec++;
              nmis++;
              $display("FAIL unexpected_done dut%0d cyc %0d: got done=1 expected no response", gi, cyc);
            end else begin
              e = sb.pop_front();
              chk("done_cycle", gi, cyc, e.done_cyc);
              chk("misalign", gi, {31'h0, ifc.misalign_o}, {31'h0, e.mis});
              chk("rdata", gi, ifc.rdata_o, e.rdata);
              chk("read_cycles", gi, nr, e.nreads);
              chk("write_cycles", gi, nw, e.nwrites);
              if (e.nwrites > 0) begin
                chk("write_cycle", gi, wc, e.wcyc);
                chk("write_addr", gi, wa, e.waddr);
                chk("write_data", gi, wd, e.wdata);
              end
            end
            nr = 0;
            nw = 0;
          end
        end
      end
    end
  endgenerate

  // One request: push expectation, hold req while stalled, drop it in RESP.
  task automatic issue(input int d, input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd, input int lat,
                       input logic mis, input logic [31:0] rd, input int nrd,
                       input int nwr, input int wofs, input logic [31:0] wexp);
    exp_t e;
    int   sc;
    @(negedge clk);
    req[d] = 1'b1; we[d] = w; size[d] = sz; uns[d] = u; addr[d] = a; wdata[d] = wd;
    e.dut = d; e.done_cyc = cyc + lat; e.mis = mis; e.rdata = rd;
    e.nreads = nrd; e.nwrites = nwr; e.wcyc = cyc + wofs;
    e.waddr = {a[31:2], 2'b00}; e.wdata = wexp;
    sb.push_back(e);
    $display("req dut%0d we=%0b size=%b uns=%0b addr=%h wdata=%h -> mis=%0b rdata=%h",
             d, w, sz, u, a, wd, mis, rd);
    sc = 0;
    #1;
    while (stall_a[d] && sc < 100) begin
      sc++;
      @(negedge clk);
      #1;
    end
    req[d] = 1'b0;
    chk("stall_cycles", d, sc, lat);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req[d] = 1'b0; we[d] = 1'b0; size[d] = 2'b00;
      uns[d] = 1'b0; addr[d] = 32'h0; wdata[d] = 32'h0;
      for (int i = 0; i < 64; i++) mem[d][i] = 32'h0;
    end
    repeat (3) @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_outputs", d,
          {23'h0, stall_a[d], done_a[d], mis_a[d], mrd_a[d], mwr_a[d], 4'h0} |
          rdata_a[d] | maddr_a[d] | mdata_a[d], 32'h0);
    end

    // ---- LAT=1 unit ----
    mem[0][4]  = 32'h8000_00F0;   // 0x10
    mem[0][12] = 32'h1122_3344;   // 0x30
    issue(0, 0, 2'b00, 0, 32'h10, 32'h0, 2, 0, 32'hFFFF_FFF0, 1, 0, 0, 32'h0);
    issue(0, 0, 2'b00, 1, 32'h10, 32'h0, 2, 0, 32'h0000_00F0, 1, 0, 0, 32'h0);
    issue(0, 0, 2'b01, 0, 32'h12, 32'h0, 2, 0, 32'hFFFF_8000, 1, 0, 0, 32'h0);
    issue(0, 1, 2'b10, 0, 32'h20, 32'hDEAD_BEEF, 2, 0, 32'h0, 0, 1, 1, 32'hDEAD_BEEF);
    issue(0, 0, 2'b10, 0, 32'h20, 32'h0, 2, 0, 32'hDEAD_BEEF, 1, 0, 0, 32'h0);
    issue(0, 1, 2'b00, 0, 32'h31, 32'h0000_00AA, 3, 0, 32'h0, 1, 1, 2, 32'h1122_AA44);
    mem[0][12] = 32'h1122_3344;
    issue(0, 1, 2'b01, 0, 32'h32, 32'h0000_BBCC, 3, 0, 32'h0, 1, 1, 2, 32'hBBCC_3344);
    issue(0, 0, 2'b10, 0, 32'h06, 32'h0, 1, 1, 32'h0, 0, 0, 0, 32'h0);
    issue(0, 0, 2'b01, 0, 32'h05, 32'h0, 1, 1, 32'h0, 0, 0, 0, 32'h0);
    issue(0, 0, 2'b11, 0, 32'h10, 32'h0, 1, 1, 32'h0, 0, 0, 0, 32'h0);
    issue(0, 1, 2'b10, 0, 32'h22, 32'h1234_5678, 1, 1, 32'h0, 0, 0, 0, 32'h0);
    chk("mem_after_misaligned_store", 0, mem[0][8], 32'hDEAD_BEEF);
    issue(0, 0, 2'b00, 0, 32'h33, 32'h0, 2, 0, 32'hFFFF_FFBB, 1, 0, 0, 32'h0);
    issue(0, 0, 2'b01, 1, 32'h32, 32'h0, 2, 0, 32'h0000_BBCC, 1, 0, 0, 32'h0);
    issue(0, 0, 2'b00, 1, 32'h30, 32'h0, 2, 0, 32'h0000_0044, 1, 0, 0, 32'h0);

    // ---- LAT=3 unit ----
    mem[1][16] = 32'h0BAD_F00D;   // 0x40
    issue(1, 0, 2'b10, 0, 32'h40, 32'h0, 4, 0, 32'h0BAD_F00D, 3, 0, 0, 32'h0);
    repeat (3) @(negedge clk);
    chk("no_reaccept_stall", 1, {31'h0, stall_a[1]}, 32'h0);
    issue(1, 1, 2'b00, 0, 32'h41, 32'h0000_0055, 5, 0, 32'h0, 3, 1, 4, 32'h0BAD_550D);
    issue(1, 0, 2'b01, 0, 32'h42, 32'h0, 4, 0, 32'h0000_0BAD, 3, 0, 0, 32'h0);
    issue(1, 1, 2'b10, 0, 32'h44, 32'hCAFE_F00D, 2, 0, 32'h0, 0, 1, 1, 32'hCAFE_F00D);

    // reset during the READ phase of a byte store
    mem[1][20] = 32'h1234_5678;   // 0x50
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b1; size[1] = 2'b00; uns[1] = 1'b0;
    addr[1] = 32'h50; wdata[1] = 32'h99;
    $display("req dut1 byte store 0x99 to 00000050 with reset in READ -> abandoned");
    @(negedge clk);
    chk("in_read_before_reset", 1, {31'h0, mrd_a[1]}, 32'h1);
    req[1] = 1'b0;
    rst[1] = 1'b1;
    @(negedge clk);
    chk("outputs_after_reset", 1,
        {23'h0, stall_a[1], done_a[1], mis_a[1], mrd_a[1], mwr_a[1], 4'h0} |
        rdata_a[1] | maddr_a[1] | mdata_a[1], 32'h0);
    @(negedge clk);
    rst[1] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (mwr_a[1]) begin
        nmis++;
        $display("FAIL write_after_reset dut1 cyc %0d: got mem_write=1 expected 0", cyc);
      end
    end
    chk("mem_after_reset", 1, mem[1][20], 32'h1234_5678);
    issue(1, 0, 2'b00, 1, 32'h50, 32'h0, 4, 0, 32'h0000_0078, 3, 0, 0, 32'h0);

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 0, sb.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator-side memory access unit for the MEM stage of the pipelined CPU. It takes load/store requests from the pipeline, drives the byte-addressed, little-endian, word-wide data memory port, and stalls the pipeline for the duration of each access. It handles byte and halfword accesses: loads are extracted and extended, and sub-word stores are done as read-modify-write. Misaligned and reserved-size accesses are rejected with an error flag and never reach memory.

## Interface
- `LAT`, default 1: memory read latency in cycles. Must be ≥1. Read data is sampled at the end of the LAT-th cycle with `mem_read_o` high.
- `clk_i` in 1: the only clock; all state updates on its rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `req_i` in 1: request valid from the pipeline. Held by the pipeline while `stall_o` is high.
- `we_i` in 1: 1 = store, 0 = load.
- `size_i` in 2: access size. 00 = byte, 01 = half, 10 = word, 11 = reserved.
- `unsigned_i` in 1: loads only. 1 = zero-extend, 0 = sign-extend.
- `addr_i` in 32: byte address.
- `wdata_i` in 32: store data. Low bytes are used for sub-word stores.
- `stall_o` out 1: freeze the pipeline.
- `done_o` out 1: one-cycle completion pulse.
- `misalign_o` out 1: one-cycle error pulse, coincident with `done_o`.
- `rdata_o` out 32: load result. Valid while `done_o` is high, 0 otherwise.
- `mem_addr_o` out 32: word-aligned address, `{addr[31:2],2'b00}`.
- `mem_data_o` out 32: write word to memory.
- `mem_read_o` out 1: memory read enable.
- `mem_write_o` out 1: memory write enable (writes all 4 bytes).
- `mem_data_i` in 32: read word from memory.

## Operation
- **States:** IDLE, READ, WRITE, RESP.
- **Acceptance:** a request is accepted only in IDLE with `req_i`=1. On acceptance, `we`, `size`, `unsigned`, `addr` and `wdata` are latched. `req_i` is ignored in every other state.
- **Misalignment:** a request is misaligned if any of these holds:
  - half with `addr[0]`=1;
  - word with `addr[1:0]`≠0;
  - `size`=11.
- **Transitions:**
  - Misaligned request: IDLE→RESP. `misalign_o`=1, `rdata_o`=0, no memory access.
  - Load: IDLE→READ. Stay LAT cycles, capture `mem_data_i` on the last one, then →RESP.
  - Word store: IDLE→WRITE, one cycle, then →RESP.
  - Byte/half store: IDLE→READ (LAT cycles, capture old word)→WRITE with the merged word→RESP.
  - RESP→IDLE always.
- **Load extraction:**
  - Byte: lane = `addr[1:0]`, value = `word[8*lane+7 : 8*lane]`.
  - Half: value = `word[16*addr[1]+15 : 16*addr[1]]`.
  - Word: whole word.
  - Extend to 32 bits per `unsigned_i`; ignored for word loads.
- **Store merge:** replace the addressed byte lane with `wdata[7:0]`, or the addressed half lane with `wdata[15:0]`. All other bytes keep the read value.
- **Memory outputs:**
  - In READ: `mem_read_o`=1 and `mem_addr_o` driven.
  - In WRITE: `mem_write_o`=1 and `mem_addr_o`/`mem_data_o` driven.
  - Elsewhere: all four memory outputs are 0.
  - `mem_read_o` and `mem_write_o` are never high together.
- **Stall:** `stall_o` = (IDLE & `req_i`) | READ | WRITE. It is low in RESP, so the pipeline advances in the cycle `done_o` is seen. A misaligned request therefore stalls exactly one cycle.
- **Reset:** `rst_i` in any state forces IDLE and clears all latched fields. An in-flight access is abandoned; a pending sub-word write is never issued.

## Timing
- Reset values: every output is 0; state is IDLE.
- Latency is counted from the acceptance cycle, which is cycle 0:

| Access | `done_o` cycle |
|---|---|
| Load | LAT+1 |
| Word store | 2 |
| Byte/half store | LAT+2 (write issued in cycle LAT+1) |
| Misaligned | 1 |

- `done_o`, `misalign_o` and `rdata_o` are registered and valid only in RESP.
- Back-to-back: the next request is accepted no earlier than the cycle after RESP. Minimum spacing between acceptances is latency + 1.
- READ uses a counter that runs 0..LAT-1; it leaves READ when the count reaches LAT-1.

## Test plan
- Memory word 0x8000_00F0 at address 0x10, LAT=1:
  - load byte, signed, `addr`=0x10 → `done_o` at cycle 2, `rdata_o`=0xFFFF_FFF0;
  - same load with `unsigned_i`=1 → 0x0000_00F0;
  - load half, signed, `addr`=0x12 → 0xFFFF_8000.
- Word store 0xDEAD_BEEF to 0x20 → `mem_write_o`=1 in cycle 1 only, `mem_addr_o`=0x20, `done_o` at cycle 2. A following word load from 0x20 returns 0xDEAD_BEEF.
- Memory 0x1122_3344 at 0x30:
  - byte store 0xAA to 0x31 → READ, then write 0x1122_AA44, `done_o` at cycle 3;
  - half store 0xBBCC to 0x32 → write 0xBBCC_3344.
- Word load from 0x06 → `misalign_o`=`done_o`=1 at cycle 1, `rdata_o`=0, `mem_read_o`/`mem_write_o` never asserted. Repeat for a half load at 0x05 and for `size`=11.
- `rst_i` asserted in the READ cycle of a byte store with LAT=3 → IDLE next cycle, no `mem_write_o`, memory unchanged, all outputs 0.
- LAT=3 word load with `req_i` held high throughout → `stall_o` high for cycles 0–3, `done_o` at cycle 4. Exactly one access per request; no duplicate acceptance.
